// File: rtl/pipe_add_sub_pkg.sv
// Shared constants, op encoding and parameter-legality check for the
// pipelined add/subtract unit.
`ifndef PIPE_ADD_SUB_PKG_SV
`define PIPE_ADD_SUB_PKG_SV

// Elaboration-time guard: the operand must split into equal, non-empty chunks.
`define PIPE_ADD_SUB_CHECK_PARAMS(W, S) \
  if ((S) < 1 || (S) > (W) || ((W) % (S)) != 0) begin : g_bad_params \
    $error("pipe_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH"); \
  end

package pipe_add_sub_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

`endif

// File: rtl/pipe_add_sub_stage.sv
// One registered C-bit slice of the carry chain. It also exposes the carry
// into its own MSB so the top slice can form the signed-overflow flag.
module add_pipe_stage
  import pipe_add_sub_pkg::*;
#(
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_in,
  input  logic [C-1:0] a_chunk,
  input  logic [C-1:0] b_chunk,
  input  logic         carry_in,
  output logic [C-1:0] sum_chunk,
  output logic         carry_out,
  output logic         carry_msb,
  output logic         valid_out
);

  logic [C:0] full;
  logic       cmsb_next;

  assign full = {1'b0, a_chunk} + {1'b0, b_chunk} + {{C{1'b0}}, carry_in};
  // The sum MSB is a^b^carry_into_msb, so the carry into the MSB falls out of it.
  assign cmsb_next = full[C-1] ^ a_chunk[C-1] ^ b_chunk[C-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_chunk <= '0;
      carry_out <= 1'b0;
      carry_msb <= 1'b0;
      valid_out <= 1'b0;
    end else if (en) begin
      sum_chunk <= full[C-1:0];
      carry_out <= full[C];
      carry_msb <= cmsb_next;
      valid_out <= valid_in;
    end
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit add/subtract: STAGES chained chunk adders with operand
// skew in front, sum de-skew behind, and a flag/result register at the output.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C = chunk_width(WIDTH, STAGES);

  `PIPE_ADD_SUB_CHECK_PARAMS(WIDTH, STAGES)

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. The whole pipe moves in lockstep on adv; when the output holds an
  // unconsumed result every register (bubbles included) freezes, so in_ready
  // drops and sum/flags stay stable until out_ready is seen.
  logic                    adv;
  logic                    do_sub;
  logic                    carry0;
  logic [WIDTH-1:0]        b_eff;
  logic [WIDTH-1:0]        sum_aligned;
  logic [STAGES-1:0][C-1:0] stage_sum;
  logic [STAGES-1:0]       stage_cout;
  logic [STAGES-1:0]       stage_valid;
  logic                    last_cmsb;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign do_sub   = (op_e'(sub) == OP_SUB);
  assign b_eff    = do_sub ? ~b : b;
  assign carry0   = do_sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int ODLY = STAGES - 1 - k;

    logic [C-1:0] a_in;
    logic [C-1:0] b_in;
    logic         c_in;
    logic         v_in;
    logic         cmsb;

    if (k == 0) begin : g_head
      assign a_in = a[C-1:0];
      assign b_in = b_eff[C-1:0];
      assign c_in = carry0;
      assign v_in = in_valid;
    end else begin : g_skew
      // Chunk k is consumed k cycles after acceptance, so it waits in a k-deep line.
      logic [C-1:0] a_dly [k];
      logic [C-1:0] b_dly [k];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < k; d++) begin
            a_dly[d] <= '0;
            b_dly[d] <= '0;
          end
        end else if (adv) begin
          a_dly[0] <= a[k*C +: C];
          b_dly[0] <= b_eff[k*C +: C];
          for (int d = 1; d < k; d++) begin
            a_dly[d] <= a_dly[d-1];
            b_dly[d] <= b_dly[d-1];
          end
        end
      end

      assign a_in = a_dly[k-1];
      assign b_in = b_dly[k-1];
      assign c_in = stage_cout[k-1];
      assign v_in = stage_valid[k-1];
    end

    add_pipe_stage #(
      .C (C)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .valid_in  (v_in),
      .a_chunk   (a_in),
      .b_chunk   (b_in),
      .carry_in  (c_in),
      .sum_chunk (stage_sum[k]),
      .carry_out (stage_cout[k]),
      .carry_msb (cmsb),
      .valid_out (stage_valid[k])
    );

    if (k == STAGES - 1) begin : g_msb
      assign last_cmsb = cmsb;
    end else begin : g_low
      logic unused_cmsb;
      assign unused_cmsb = cmsb;
    end

    if (ODLY == 0) begin : g_direct
      assign sum_aligned[k*C +: C] = stage_sum[k];
    end else begin : g_oskew
      // Early chunks finish first and wait here until the top chunk catches up.
      logic [C-1:0] s_dly [ODLY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < ODLY; d++) begin
            s_dly[d] <= '0;
          end
        end else if (adv) begin
          s_dly[0] <= stage_sum[k];
          for (int d = 1; d < ODLY; d++) begin
            s_dly[d] <= s_dly[d-1];
          end
        end
      end

      assign sum_aligned[k*C +: C] = s_dly[ODLY-1];
    end
  end

  // Result data only loads for real ops, so bubbles never disturb the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= stage_valid[STAGES-1];
      if (stage_valid[STAGES-1]) begin
        sum  <= sum_aligned;
        cout <= stage_cout[STAGES-1];
        ovf  <= last_cmsb ^ stage_cout[STAGES-1];
        zero <= (sum_aligned == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: directed vectors, stall/back-to-back,
// reset with ops in flight, randomized traffic and 8-bit parameter sweeps.
module tb_pipe_add_sub;

  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  logic       s_in_valid, s_cin, s_sub, s_out_ready;
  logic [7:0] s_a, s_b;
  logic       d1_in_ready, d1_out_valid, d1_cout, d1_ovf, d1_zero;
  logic [7:0] d1_sum;
  logic       d8_in_ready, d8_out_valid, d8_cout, d8_ovf, d8_zero;
  logic [7:0] d8_sum;

  int n_cmp;
  int n_fail;
  logic [W+2:0] exp_q[$];

  pipe_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) dut_w8s1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(d1_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(d1_out_valid), .out_ready(s_out_ready), .sum(d1_sum),
    .cout(d1_cout), .ovf(d1_ovf), .zero(d1_zero)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(8)) dut_w8s8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(d8_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(d8_out_valid), .out_ready(s_out_ready), .sum(d8_sum),
    .cout(d8_cout), .ovf(d8_ovf), .zero(d8_zero)
  );

  // Reference: plain w-bit arithmetic, result packed as {sum, cout, ovf, zero}.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub, input int w);
    longint unsigned mask, x, y, t, s;
    logic c, o, z, sx, sy, ss;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, ma} & mask;
    y = (msub ? {32'd0, ~mb} : {32'd0, mb}) & mask;
    t = x + y + (msub ? 64'd1 : {63'd0, mcin});
    s = t & mask;
    c = ((t >> w) & 64'd1) != 0;
    sx = ((x >> (w - 1)) & 64'd1) != 0;
    sy = ((y >> (w - 1)) & 64'd1) != 0;
    ss = ((s >> (w - 1)) & 64'd1) != 0;
    o = (sx == sy) && (ss != sx);
    z = (s == 0);
    return {s[W-1:0], c, o, z};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; s_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one op into the 32-bit unit and measures cycles until out_valid.
  task automatic drive_one(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                           input logic tsub, output logic [W+2:0] got, output int lat);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = -1; got = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i; got = {sum, cout, ovf, zero};
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 0", sum); end
    n_cmp++; if ({cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {cout, ovf, zero}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if ({d1_out_valid, d8_out_valid, d1_in_ready, d8_in_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL reset_sweep got %b want 0011", {d1_out_valid, d8_out_valid, d1_in_ready, d8_in_ready});
    end
    // Bubbles alone must leave the outputs at their reset values.
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if ({out_valid, sum, cout, ovf, zero} !== '0) begin
      n_fail++; $display("FAIL idle_outputs got %b/%h/%b want 0/0/000", out_valid, sum, {cout, ovf, zero});
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] sum;
    logic         cout, ovf, zero;
    string        name;
  } vec_t;

  task automatic test_vectors();
    vec_t vt[5];
    logic [W+2:0] got;
    int lat;
    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "add_wrap"};
    vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf"};
    vt[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 1'b0, "add_chunk_carry"};
    vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_borrow"};
    vt[4] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_equal_cin"};
    for (int i = 0; i < 5; i++) begin
      drive_one(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, got, lat);
      n_cmp++; if (lat != S) begin n_fail++; $display("FAIL %s latency got %0d want %0d", vt[i].name, lat, S); end
      n_cmp++; if (got[W+2:3] !== vt[i].sum) begin n_fail++; $display("FAIL %s sum got %h want %h", vt[i].name, got[W+2:3], vt[i].sum); end
      n_cmp++; if (got[2] !== vt[i].cout) begin n_fail++; $display("FAIL %s cout got %0b want %0b", vt[i].name, got[2], vt[i].cout); end
      n_cmp++; if (got[1] !== vt[i].ovf) begin n_fail++; $display("FAIL %s ovf got %0b want %0b", vt[i].name, got[1], vt[i].ovf); end
      n_cmp++; if (got[0] !== vt[i].zero) begin n_fail++; $display("FAIL %s zero got %0b want %0b", vt[i].name, got[0], vt[i].zero); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, stall = 0, cyc = 0;
    logic stall_done = 1'b0;
    logic [W-1:0] held, na, nb;
    logic ncin, nsub;
    logic [W+2:0] e;
    exp_q.delete();
    na = pick_operand(); nb = pick_operand(); ncin = 1'($urandom_range(0, 1)); nsub = 1'($urandom_range(0, 1));
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      if (!stall_done && stall == 0 && out_valid) stall = 1;
      out_ready = !(stall >= 1 && stall <= 3);
      in_valid = (sent < 6);
      a = na; b = nb; cin = ncin; sub = nsub;
      #1;
      if (!out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle %0d got %0b want 0", stall, in_ready); end
        if (stall == 1) held = sum;
        else begin
          n_cmp++; if (sum !== held) begin n_fail++; $display("FAIL stall_sum_hold cycle %0d got %h want %h", stall, sum, held); end
        end
        stall++;
        if (stall > 3) begin stall_done = 1'b1; stall = 0; end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra_result got %h want none", sum); end
        else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf, zero} !== e) begin n_fail++; $display("FAIL b2b_result %0d got %h/%b want %h/%b", got, sum, {cout, ovf, zero}, e[W+2:3], e[2:0]); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub, W));
        sent++;
        na = pick_operand(); nb = pick_operand(); ncin = 1'($urandom_range(0, 1)); nsub = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != 6 || !stall_done) begin n_fail++; $display("FAIL b2b_count got %0d stall_done %0b want 6 1", got, stall_done); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    logic [W+2:0] got, e;
    logic [W-1:0] ta, tb;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = pick_operand(); b = pick_operand(); cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_reset_edge out_valid got %0b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_ghost cycle %0d out_valid got %0b want 0", i, out_valid); end
    end
    ta = $urandom; tb = $urandom;
    e = model(ta, tb, 1'b1, 1'b0, W);
    drive_one(ta, tb, 1'b1, 1'b0, got, lat);
    n_cmp++; if (lat != S) begin n_fail++; $display("FAIL inflight_new_latency got %0d want %0d", lat, S); end
    n_cmp++; if (got !== e) begin n_fail++; $display("FAIL inflight_new_result got %h want %h", got, e); end
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0;
    logic [W+2:0] e;
    exp_q.delete();
    while ((sent < 40 || got < sent) && cyc < 800) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
      a = pick_operand(); b = pick_operand();
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      n_cmp++; if (in_ready !== (!out_valid || out_ready)) begin n_fail++; $display("FAIL rand_in_ready got %0b want %0b", in_ready, !out_valid || out_ready); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra_result got %h want none", sum); end
        else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf, zero} !== e) begin n_fail++; $display("FAIL rand_result %0d got %h/%b want %h/%b", got, sum, {cout, ovf, zero}, e[W+2:3], e[2:0]); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub, W));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (sent != 40 || got != 40) begin n_fail++; $display("FAIL rand_count got %0d/%0d want 40/40", sent, got); end
  endtask

  task automatic test_sweep();
    logic [W+2:0] e;
    logic [10:0] exp8, g1, g8;
    int l1, l8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin s_a = 8'h80; s_b = 8'h01; s_cin = 1'b0; s_sub = 1'b1; exp8 = {8'h7F, 1'b1, 1'b1, 1'b0}; end
      else begin
        s_a = 8'($urandom); s_b = 8'($urandom); s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
        e = model({24'd0, s_a}, {24'd0, s_b}, s_cin, s_sub, 8);
        exp8 = {e[10:3], e[2:0]};
      end
      s_in_valid = 1'b1; s_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_in_valid = 1'b0;
      l1 = -1; l8 = -1; g1 = '0; g8 = '0;
      for (int c = 1; c <= 20 && (l1 < 0 || l8 < 0); c++) begin
        @(posedge clk); #1;
        if (l1 < 0 && d1_out_valid) begin l1 = c; g1 = {d1_sum, d1_cout, d1_ovf, d1_zero}; end
        if (l8 < 0 && d8_out_valid) begin l8 = c; g8 = {d8_sum, d8_cout, d8_ovf, d8_zero}; end
      end
      @(posedge clk);
      n_cmp++; if (l1 != 1) begin n_fail++; $display("FAIL w8s1_latency op %0d got %0d want 1", i, l1); end
      n_cmp++; if (l8 != 8) begin n_fail++; $display("FAIL w8s8_latency op %0d got %0d want 8", i, l8); end
      n_cmp++; if (g1 !== exp8) begin n_fail++; $display("FAIL w8s1_result op %0d got %h/%b want %h/%b", i, g1[10:3], g1[2:0], exp8[10:3], exp8[2:0]); end
      n_cmp++; if (g8 !== exp8) begin n_fail++; $display("FAIL w8s8_result op %0d got %h/%b want %h/%b", i, g8[10:3], g8[2:0], exp8[10:3], exp8[2:0]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
